// File: rtl/multicycle_control_unit_if.sv
// Instruction/data memory handshake bundle between the control unit (master)
// and the memory side (slave).
interface multicycle_control_unit_if #(
  parameter int OPCODE_WIDTH = 6
);
  logic                    imem_req;
  logic                    imem_ack;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    dmem_req;
  logic                    dmem_ack;
  logic                    memory_write_enable;

  modport master (
    output imem_req, dmem_req, memory_write_enable,
    input  imem_ack, dmem_ack, opcode
  );

  modport slave (
    input  imem_req, dmem_req, memory_write_enable,
    output imem_ack, dmem_ack, opcode
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle sequencer: walks the datapath through fetch/decode/execute/memory/
// writeback with memory handshakes, a watchdog, illegal-opcode trap and retire counter.
//
// state       | meaning
// S_FETCH     | imem_req high until imem_ack; opcode latched on ack
// S_DECODE    | one cycle, decode fields become valid
// S_EXECUTE   | one cycle, ALU controls valid, jz resolves branch
// S_MEMORY    | dmem_req high until dmem_ack or watchdog expiry
// S_WRITEBACK | one-cycle pc/register/stack strobes, retire
// S_ERROR     | absorbing trap, left only through reset
module multicycle_control_unit #(
  parameter int OPCODE_WIDTH   = 6,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_control_unit_if.master mem,
  input  logic                   zero_flag,
  output logic                   stack_control,
  output logic                   stack_write_enable,
  output logic                   write_data_enable,
  output logic                   pc_increment_control,
  output logic [1:0]             pc_control,
  output logic                   pc_write,
  output logic                   branch,
  output logic                   general_register_write_enable,
  output logic [1:0]             general_register_result_select,
  output logic [1:0]             ALU_source_2,
  output logic [1:0]             ALU_control,
  output logic                   illegal_opcode,
  output logic                   timeout_error,
  output logic [CNT_WIDTH-1:0]   retired_count
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_ERROR
  } state_t;

  typedef logic [OPCODE_WIDTH-1:0] op_t;

  localparam op_t OP_LD   = op_t'(0);
  localparam op_t OP_STR  = op_t'(1);
  localparam op_t OP_ADD  = op_t'(2);
  localparam op_t OP_SUB  = op_t'(3);
  localparam op_t OP_AND  = op_t'(4);
  localparam op_t OP_OR   = op_t'(5);
  localparam op_t OP_MOV  = op_t'(6);
  localparam op_t OP_CMP  = op_t'(7);
  localparam op_t OP_JZ   = op_t'(8);
  localparam op_t OP_JMP  = op_t'(9);
  localparam op_t OP_MOVI = op_t'(10);
  localparam op_t OP_ADDI = op_t'(11);
  localparam op_t OP_SUBI = op_t'(12);
  localparam op_t OP_ANDI = op_t'(13);
  localparam op_t OP_ORI  = op_t'(14);
  localparam op_t OP_PUSH = op_t'(15);
  localparam op_t OP_POP  = op_t'(16);
  localparam op_t OP_CALL = op_t'(17);
  localparam op_t OP_RET  = op_t'(18);

  // Watchdog is a down-counter loaded on MEMORY entry; terminal count 0 is the last wait cycle.
  localparam int WD_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_WIDTH-1:0] WD_INIT = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t              state, state_nxt;
  op_t                 opc_q;
  logic [WD_WIDTH-1:0] wd_cnt;
  logic                op_illegal;
  logic                is_mem, is_store, writes_reg, is_stack;
  logic                fetch_done, wd_expired;

  assign op_illegal = mem.opcode > OP_RET;
  assign fetch_done = (state == S_FETCH) && mem.imem_ack;
  assign wd_expired = (state == S_MEMORY) && !mem.dmem_ack && (wd_cnt == '0);
  assign is_stack   = (opc_q == OP_PUSH) || (opc_q == OP_POP) ||
                      (opc_q == OP_CALL) || (opc_q == OP_RET);

  always_comb begin
    is_mem     = 1'b0;
    is_store   = 1'b0;
    writes_reg = 1'b0;
    case (opc_q)
      OP_LD:                    begin is_mem = 1'b1; writes_reg = 1'b1; end
      OP_STR, OP_PUSH, OP_CALL: begin is_mem = 1'b1; is_store = 1'b1; end
      OP_POP:                   begin is_mem = 1'b1; writes_reg = 1'b1; end
      OP_RET:                   is_mem = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV,
      OP_MOVI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: writes_reg = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opc_q          <= '0;
      wd_cnt         <= '0;
      retired_count  <= '0;
      illegal_opcode <= 1'b0;
      timeout_error  <= 1'b0;
    end else begin
      if (fetch_done) opc_q <= mem.opcode;
      if (fetch_done && op_illegal) illegal_opcode <= 1'b1;
      if (state == S_EXECUTE) wd_cnt <= WD_INIT;
      else if (state == S_MEMORY && !mem.dmem_ack && wd_cnt != '0) wd_cnt <= wd_cnt - WD_WIDTH'(1);
      if (wd_expired) timeout_error <= 1'b1;
      if (state == S_WRITEBACK) retired_count <= retired_count + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:     if (mem.imem_ack) state_nxt = op_illegal ? S_ERROR : S_DECODE;
      S_DECODE:    state_nxt = S_EXECUTE;
      S_EXECUTE:   state_nxt = is_mem ? S_MEMORY : S_WRITEBACK;
      S_MEMORY:    if (mem.dmem_ack) state_nxt = S_WRITEBACK;
                   else if (wd_cnt == '0) state_nxt = S_ERROR;
      S_WRITEBACK: state_nxt = S_FETCH;
      S_ERROR:     state_nxt = S_ERROR;
      default:     state_nxt = S_ERROR;
    endcase
  end

  always_comb begin
    mem.imem_req                   = 1'b0;
    mem.dmem_req                   = 1'b0;
    mem.memory_write_enable        = 1'b0;
    stack_control                  = 1'b0;
    stack_write_enable             = 1'b0;
    write_data_enable              = 1'b0;
    pc_increment_control           = 1'b0;
    pc_control                     = 2'b00;
    pc_write                       = 1'b0;
    branch                         = 1'b0;
    general_register_write_enable  = 1'b0;
    general_register_result_select = 2'b00;
    ALU_source_2                   = 2'b00;
    ALU_control                    = 2'b00;
    if (state == S_DECODE || state == S_EXECUTE || state == S_MEMORY || state == S_WRITEBACK) begin
      case (opc_q)
        OP_ADD:  general_register_result_select = 2'b01;
        OP_SUB:  begin general_register_result_select = 2'b01; ALU_control = 2'b01; end
        OP_AND:  begin general_register_result_select = 2'b01; ALU_control = 2'b10; end
        OP_OR:   begin general_register_result_select = 2'b01; ALU_control = 2'b11; end
        OP_MOV:  general_register_result_select = 2'b10;
        OP_CMP:  ALU_control = 2'b01;
        OP_JZ:   pc_increment_control = 1'b1;
        OP_JMP:  pc_control = 2'b01;
        OP_MOVI: begin pc_increment_control = 1'b1; general_register_result_select = 2'b11; ALU_source_2 = 2'b01; end
        OP_ADDI: begin pc_increment_control = 1'b1; general_register_result_select = 2'b01; ALU_source_2 = 2'b01; end
        OP_SUBI: begin pc_increment_control = 1'b1; general_register_result_select = 2'b01; ALU_source_2 = 2'b01; ALU_control = 2'b01; end
        OP_ANDI: begin pc_increment_control = 1'b1; general_register_result_select = 2'b01; ALU_source_2 = 2'b01; ALU_control = 2'b10; end
        OP_ORI:  begin pc_increment_control = 1'b1; general_register_result_select = 2'b01; ALU_source_2 = 2'b01; ALU_control = 2'b11; end
        OP_PUSH: ALU_source_2 = 2'b10;
        OP_POP:  begin ALU_source_2 = 2'b10; ALU_control = 2'b01; stack_control = 1'b1; end
        OP_CALL: begin ALU_source_2 = 2'b10; pc_control = 2'b01; write_data_enable = 1'b1; end
        OP_RET:  begin ALU_source_2 = 2'b10; ALU_control = 2'b01; stack_control = 1'b1; pc_control = 2'b10; end
        default: ;
      endcase
    end
    case (state)
      // Gated so nothing is requested while reset is still asserted.
      S_FETCH:     mem.imem_req = reset_n;
      S_EXECUTE:   branch = (opc_q == OP_JZ) && zero_flag;
      S_MEMORY:    begin mem.dmem_req = 1'b1; mem.memory_write_enable = is_store; end
      S_WRITEBACK: begin
        pc_write                      = 1'b1;
        general_register_write_enable = writes_reg;
        stack_write_enable            = is_stack;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequential successor to the single-cycle opcode decoder.
- Drives the datapath through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and handshakes with instruction and data memories, whose latency over the photonic interconnect is variable.
- Has a parametrised opcode width, a memory-timeout watchdog, illegal-opcode trapping and a retired-instruction counter.

Parameters:
- OPCODE_WIDTH, 6, opcode field width. Must be ≥5.
- TIMEOUT_CYCLES, 64, max cycles a memory request may wait for ack before ERROR.
- CNT_WIDTH, 32, retired-instruction counter width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  OPCODE_WIDTH  opcode of fetched instruction, valid when imem_ack=1
- zero_flag  in  1  ALU zero flag, sampled in EXECUTE
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction fetch complete
- dmem_req  out  1  data memory request
- dmem_ack  in  1  data access complete
- memory_write_enable  out  1  write qualifier for dmem_req
- stack_control  out  1  stack pointer direction (1 = pop/return)
- stack_write_enable  out  1  stack pointer update strobe
- write_data_enable  out  1  select PC+1 as store data (call)
- pc_increment_control  out  1  PC step 2 (two-word instruction)
- pc_control  out  2  00 sequential, 01 jump target, 10 stack return
- pc_write  out  1  PC update strobe
- branch  out  1  conditional branch taken
- general_register_write_enable  out  1  register file write strobe
- general_register_result_select  out  2  00 memory, 01 ALU, 10 register, 11 immediate
- ALU_source_2  out  2  00 register, 01 immediate, 10 stack constant
- ALU_control  out  2  00 add, 01 sub, 10 and, 11 or
- illegal_opcode  out  1  sticky trap flag
- timeout_error  out  1  sticky watchdog flag
- retired_count  out  CNT_WIDTH  instructions completed

Behaviour:
- Opcodes (decimal): 0 ld, 1 str, 2 add, 3 sub, 4 and, 5 or, 6 mov, 7 cmp, 8 jz, 9 jmp, 10 movi, 11 addi, 12 subi, 13 andi, 14 ori, 15 push, 16 pop, 17 call, 18 return. Any other value is illegal.
- Reset (async, reset_n=0): state=FETCH. All outputs 0, counter 0, sticky flags 0, watchdog 0.
- Opcode latch: captured in an internal register on the cycle imem_ack=1 in FETCH. Decode fields are driven from this latch only.
- FETCH:
  - imem_req=1 until imem_ack is sampled 1, then go to DECODE.
  - Latched opcode illegal -> ERROR with illegal_opcode=1.
- DECODE: 1 cycle; decode fields become valid.
- EXECUTE:
  - 1 cycle; ALU_control and ALU_source_2 valid.
  - jz: branch = zero_flag.
  - ld/str/push/pop/call/return -> MEMORY; all others -> WRITEBACK.
- MEMORY:
  - dmem_req=1 until dmem_ack=1, then WRITEBACK.
  - memory_write_enable=1 for str/push/call during the whole request.
  - Watchdog resets on entry and increments each waiting cycle. Reaching TIMEOUT_CYCLES without ack -> ERROR with timeout_error=1.
- WRITEBACK, single-cycle strobes:
  - pc_write=1.
  - general_register_write_enable=1 for ld, add, sub, and, or, mov, movi, addi, subi, andi, ori, pop.
  - stack_write_enable=1 for push/pop/call/return.
  - retired_count increments, wrapping modulo 2^CNT_WIDTH.
  - Next state is FETCH.
- Static decode fields (held stable from DECODE through WRITEBACK; 0 in FETCH/ERROR):
  - pc_increment_control=1 for opcodes 8 and 10–14.
  - pc_control=01 for jmp/call, 10 for return.
  - write_data_enable=1 for call.
  - stack_control=1 for pop/return.
  - result_select: ld/pop 00, ALU ops 01, mov 10, movi 11.
  - ALU_control: add/addi/push/call 00, sub/subi/cmp/pop/return 01, and/andi 10, or/ori 11.
  - ALU_source_2: register ops 00, immediate ops 01, stack ops 10.
- ERROR: absorbing. All strobes and requests 0, flags held; exit only by reset.
- Ack handling: an ack arriving while the matching req=0 is ignored. Requests never deassert before ack, except on timeout or reset.
- Reset mid-MEMORY: dmem_req drops asynchronously and no writeback occurs.
- Latency: non-memory instruction = 4 cycles with zero-wait imem_ack. Memory instruction = 4 + (cycles in MEMORY).

Test Plan:
- Reset held, then released with imem_ack=1, opcode=2 (add) -> imem_req high 1 cycle; WRITEBACK on cycle 4 with general_register_write_enable=1, result_select=01, ALU_control=00; retired_count=1.
- ld with dmem_ack delayed 3 cycles -> dmem_req high exactly 3 cycles, memory_write_enable=0; writeback on the cycle after ack; total 7 cycles.
- jz with zero_flag=1, then with zero_flag=0 -> branch=1 and branch=0 respectively in EXECUTE; pc_increment_control=1 both times.
- opcode=6'b111111 -> illegal_opcode=1, no pc_write or register write afterwards; cleared only by reset_n=0.
- str with dmem_ack never asserted, TIMEOUT_CYCLES=64 -> timeout_error=1 after 64 request cycles; dmem_req=0 thereafter.
- reset_n pulsed low during call's MEMORY -> all outputs 0 immediately, no stack_write_enable pulse; restart in FETCH.
